rv_regfile_ctrl: RTL and testbench
==================================

# rv_regfile_ctrl

Controller in front of the uRV register file that arbitrates its read and write ports between the pipeline and a debug access port. A debug request stalls the pipeline, waits for it to drain, performs one register read or write, and hands the ports back. The block can optionally sequence a hardware clear of x1..x31 after reset. This is needed because register contents are otherwise initialised only in simulation.

## Interface
Parameters:
- None.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- p_rs1_i, p_rs2_i  in  5  pipeline read addresses
- p_rd_i  in  5  pipeline write address
- p_rd_value_i  in  32  pipeline write data
- p_rd_store_i  in  1  pipeline write enable
- p_idle_i  in  1  pipeline drained: no store in flight or pending
- stall_o  out  1  pipeline stall request
- init_done_o  out  1  register file ready
- rf_rs1_o, rf_rs2_o  out  5  register file read addresses
- rf_rd_o  out  5  register file write address
- rf_rd_value_o  out  32  register file write data
- rf_rd_store_o  out  1  register file write enable
- rf_rs1_value_i  in  32  rs1 read data, valid 1 cycle after the address
- dbg_req_i  in  1  debug request (level, four-phase handshake)
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  5  register index
- dbg_wdata_i  in  32  write data
- dbg_ack_o  out  1  transaction complete
- dbg_rdata_o  out  32  read data, valid while dbg_ack_o is high

## Operation
- States: CLEAR, IDLE, DRAIN, READ, READ_WAIT, WRITE, ACK, RELEASE.
- Reset values:
  - State is CLEAR if the macro is defined, otherwise IDLE.
  - stall_o = 1 if the macro is defined, otherwise 0.
  - init_done_o = 0 if the macro is defined, otherwise 1.
  - dbg_ack_o = 0 and dbg_rdata_o = 0.
  - The clear counter resets to 1.
- Port ownership:
  - In IDLE and DRAIN, rf_* pass the p_* signals through unchanged.
  - In all other states the controller owns the rf_* ports, and rf_rd_store_o is 0 unless the controller itself is writing.
  - p_rd_store_i is ignored while the controller owns the ports; p_idle_i guarantees that it is low.
- IDLE:
  - If init_done_o = 1 and dbg_req_i = 1, latch dbg_we_i, dbg_addr_i and dbg_wdata_i, then go to DRAIN.
- DRAIN:
  - stall_o = 1.
  - If p_idle_i = 1, go to READ when we = 0 or to WRITE when we = 1. Otherwise stay in DRAIN.
- READ: drive rf_rs1_o = latched address, then go to READ_WAIT.
- READ_WAIT:
  - Capture dbg_rdata_o = rf_rs1_value_i, forced to 0 when the address is 0.
  - Go to ACK.
- WRITE:
  - Drive rf_rd_o = address, rf_rd_value_o = data, rf_rd_store_o = 1 for one cycle.
  - A write to address 0 is suppressed: rf_rd_store_o stays 0, but the transaction is still acknowledged.
  - Go to ACK.
- ACK:
  - dbg_ack_o = 1 and stall_o = 1.
  - Stay in ACK until dbg_req_i = 0, then go to RELEASE.
- RELEASE:
  - stall_o = 1, dbg_ack_o = 0, and the rf read addresses return to p_rs1_i/p_rs2_i so that the pipeline's operand reads refresh.
  - Go to IDLE after one cycle.
- stall_o is 1 in every state except IDLE.

## Timing
- Minimum latency, with p_idle_i already 1, counting cycle 0 as the edge at which IDLE samples the request:
  - Read: dbg_ack_o rises at cycle 4 (DRAIN 1, READ 2, READ_WAIT 3, ACK 4).
  - Write: dbg_ack_o rises at cycle 3; rf_rd_store_o is high in cycle 2.
- stall_o rises the cycle after the request is sampled. It falls two cycles after dbg_req_i is sampled low in ACK: one cycle in RELEASE, then IDLE.
- A request held high through RELEASE starts a new transaction from IDLE. Back-to-back transactions therefore require dbg_req_i to drop first.
- dbg_rdata_o holds its value until the next read captures new data.
- Reset asserted mid-transaction takes effect immediately and asynchronously:
  - dbg_ack_o drops.
  - Any pending write is abandoned.
  - CLEAR restarts from x1 (macro defined).

## Configuration
- URV_REGFILE_CLEAR_EN defined:
  - After reset the block sits in CLEAR with stall_o = 1.
  - It writes 0 to x1..x31 on consecutive cycles, using rf_rd_store_o = 1 with the counter as rf_rd_o (31 cycles).
  - After writing x31, init_done_o goes to 1 and the state moves to IDLE.
  - dbg_req_i is ignored until then.
- URV_REGFILE_CLEAR_EN undefined:
  - The CLEAR state and counter are absent.
  - init_done_o is constant 1.

## Test plan
- Macro defined, release reset: rf_rd_store_o is high for exactly 31 cycles with rf_rd_o = 1..31 and data 0, then init_done_o = 1 and stall_o = 0.
- Write x5 = 0xDEADBEEF with p_idle_i = 1: ack at cycle 3, then a read of x5 returns 0xDEADBEEF at cycle 4 after its request.
- Hold p_idle_i = 0 for 10 cycles after a request: the controller stays in DRAIN with stall_o = 1 and no rf write; ack comes 3 or 4 cycles after p_idle_i rises.
- Write x0 = 0x12345678: rf_rd_store_o never rises, ack is still given, and a read of x0 returns 0.
- Hold dbg_req_i high for 5 cycles after ack: dbg_ack_o stays high for all 5; after req drops, stall_o falls 2 cycles later.
- Assert rst_i during READ_WAIT: dbg_ack_o and dbg_rdata_o are 0 immediately; the macro-defined clear restarts at x1.

Source files
------------

// File: rtl/rv_regfile_ctrl.sv
// rv_regfile_ctrl: uRV register file port arbiter with a debug access port.
// Define URV_REGFILE_CLEAR_EN to zero x1..x31 in hardware after reset.
module rv_regfile_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  p_rs1_i,
    input  logic [4:0]  p_rs2_i,
    input  logic [4:0]  p_rd_i,
    input  logic [31:0] p_rd_value_i,
    input  logic        p_rd_store_i,
    input  logic        p_idle_i,
    output logic        stall_o,
    output logic        init_done_o,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o,
    input  logic [31:0] rf_rs1_value_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o
);
    typedef enum logic [2:0] {CLEAR, IDLE, DRAIN, READ, READ_WAIT, WRITE, ACK, RELEASE} state_t;
    state_t      state;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        clearing;
    logic [4:0]  clr_idx;
    logic        pass_wr;
    logic        pass_rd;
`ifdef URV_REGFILE_CLEAR_EN
    logic [4:0]  cnt;
    logic        done;
    assign clearing    = state == CLEAR;
    assign clr_idx     = cnt;
    assign init_done_o = done;
`else
    assign clearing    = 1'b0;
    assign clr_idx     = 5'd0;
    assign init_done_o = 1'b1;
`endif
    assign pass_wr = state == IDLE || state == DRAIN;
    // RELEASE hands the read ports back a cycle early so operand reads refresh before unstall
    assign pass_rd = pass_wr || state == RELEASE;
    assign rf_rs1_o      = pass_rd ? p_rs1_i : addr;
    assign rf_rs2_o      = pass_rd ? p_rs2_i : addr;
    assign rf_rd_o       = pass_wr ? p_rd_i : clearing ? clr_idx : addr;
    assign rf_rd_value_o = pass_wr ? p_rd_value_i : clearing ? 32'd0 : wdata;
    assign rf_rd_store_o = pass_wr ? p_rd_store_i : clearing || (state == WRITE && addr != 5'd0);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
`ifdef URV_REGFILE_CLEAR_EN
            state   <= CLEAR;
            stall_o <= 1'b1;
            cnt     <= 5'd1;
            done    <= 1'b0;
`else
            state   <= IDLE;
            stall_o <= 1'b0;
`endif
            we          <= 1'b0;
            addr        <= 5'd0;
            wdata       <= 32'd0;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= 32'd0;
        end else begin
            case (state)
`ifdef URV_REGFILE_CLEAR_EN
                CLEAR: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state   <= IDLE;
                        stall_o <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                IDLE: if (init_done_o && dbg_req_i) begin
                    we      <= dbg_we_i;
                    addr    <= dbg_addr_i;
                    wdata   <= dbg_wdata_i;
                    stall_o <= 1'b1;
                    state   <= DRAIN;
                end
                DRAIN: if (p_idle_i) state <= we ? WRITE : READ;
                READ: state <= READ_WAIT;
                READ_WAIT: begin
                    dbg_rdata_o <= addr == 5'd0 ? 32'd0 : rf_rs1_value_i;
                    dbg_ack_o   <= 1'b1;
                    state       <= ACK;
                end
                WRITE: begin
                    dbg_ack_o <= 1'b1;
                    state     <= ACK;
                end
                ACK: if (!dbg_req_i) begin
                    dbg_ack_o <= 1'b0;
                    state     <= RELEASE;
                end
                RELEASE: begin
                    stall_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_regfile_ctrl.sv
// tb_rv_regfile_ctrl: directed bench for rv_regfile_ctrl with a transaction-level reference model.
module tb_rv_regfile_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  p_rs1_i = 5'd0, p_rs2_i = 5'd0, p_rd_i = 5'd0;
    logic [31:0] p_rd_value_i = 32'd0;
    logic        p_rd_store_i = 1'b0, p_idle_i = 1'b1;
    logic        stall_o, init_done_o, rf_rd_store_o, dbg_ack_o;
    logic [4:0]  rf_rs1_o, rf_rs2_o, rf_rd_o;
    logic [31:0] rf_rd_value_o, rf_rs1_value_i, dbg_rdata_o;
    logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = 5'd0;
    logic [31:0] dbg_wdata_i = 32'd0;
    int checks = 0;
    int failures = 0;
`ifdef URV_REGFILE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    rv_regfile_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p_rs1_i(p_rs1_i), .p_rs2_i(p_rs2_i), .p_rd_i(p_rd_i),
        .p_rd_value_i(p_rd_value_i), .p_rd_store_i(p_rd_store_i), .p_idle_i(p_idle_i),
        .stall_o(stall_o), .init_done_o(init_done_o),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .rf_rd_o(rf_rd_o),
        .rf_rd_value_o(rf_rd_value_o), .rf_rd_store_o(rf_rd_store_o),
        .rf_rs1_value_i(rf_rs1_value_i),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file array behind the controller; x0 holds garbage to prove reads of x0 are forced.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_q = 32'd0;
    assign rf_rs1_value_i = rf_q;
    always @(posedge clk_i) begin
        if (rf_rd_store_o) rf_mem[rf_rd_o] <= rf_rd_value_o;
        rf_q <= rf_mem[rf_rs1_o];
    end

    // Reference model: what the register file must hold and what the debug side must see.
    logic [31:0] m_mem [32];
    int          m_clr, go;
    bit          txn, rel, t_we;
    logic [4:0]  t_addr;
    logic [31:0] t_data;
    logic        exp_stall, exp_ack, exp_done;
    logic [31:0] exp_rdata;
    initial for (int i = 0; i < 32; i++) begin
        rf_mem[i] = 32'h1000_0000 + i;
        m_mem[i]  = i == 0 ? 32'd0 : 32'h1000_0000 + i;
    end
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_clr     <= CLR ? 1 : 0;
            exp_done  <= !CLR;
            exp_stall <= CLR;
            exp_ack   <= 1'b0;
            exp_rdata <= 32'd0;
            txn       <= 1'b0;
            rel       <= 1'b0;
            go        <= -1;
        end else if (m_clr != 0) begin
            m_mem[m_clr] <= 32'd0;
            m_clr <= m_clr == 31 ? 0 : m_clr + 1;
            if (m_clr == 31) begin
                exp_done  <= 1'b1;
                exp_stall <= 1'b0;
            end
        end else if (rel) begin
            rel       <= 1'b0;
            exp_stall <= 1'b0;
        end else if (!txn) begin
            if (exp_done && dbg_req_i) begin
                txn <= 1'b1; t_we <= dbg_we_i; t_addr <= dbg_addr_i; t_data <= dbg_wdata_i;
                go <= -1; exp_stall <= 1'b1;
            end
        end else if (go < 0) begin
            if (p_idle_i) go <= 0;
        end else if (!exp_ack) begin
            // writes finish one cycle after the drain, reads two (address then data)
            if (t_we) begin
                if (t_addr != 5'd0) m_mem[t_addr] <= t_data;
                exp_ack <= 1'b1;
            end else if (go == 1) begin
                exp_rdata <= t_addr == 5'd0 ? 32'd0 : m_mem[t_addr];
                exp_ack   <= 1'b1;
            end
            go <= go + 1;
        end else if (!dbg_req_i) begin
            exp_ack <= 1'b0;
            txn     <= 1'b0;
            rel     <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (!rst_i) begin
        chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
        chk("ack", {31'd0, dbg_ack_o}, {31'd0, exp_ack});
        chk("init_done", {31'd0, init_done_o}, {31'd0, exp_done});
        chk("rdata", dbg_rdata_o, exp_rdata);
        if (m_clr != 0) begin
            chk("clr_store", {31'd0, rf_rd_store_o}, 32'd1);
            chk("clr_rd", {27'd0, rf_rd_o}, m_clr);
            chk("clr_val", rf_rd_value_o, 32'd0);
        end else if (txn && go == 0 && t_we) begin
            chk("wr_store", {31'd0, rf_rd_store_o}, {31'd0, t_addr != 5'd0});
            chk("wr_rd", {27'd0, rf_rd_o}, {27'd0, t_addr});
            chk("wr_val", rf_rd_value_o, t_data);
        end else if (txn && go == 0) begin
            chk("rd_rs1", {27'd0, rf_rs1_o}, {27'd0, t_addr});
            chk("rd_store", {31'd0, rf_rd_store_o}, 32'd0);
        end else if (rel) begin
            chk("rel_rs1", {27'd0, rf_rs1_o}, {27'd0, p_rs1_i});
            chk("rel_rs2", {27'd0, rf_rs2_o}, {27'd0, p_rs2_i});
            chk("rel_store", {31'd0, rf_rd_store_o}, 32'd0);
        end else if (!txn || go < 0) begin
            chk("pass_rs1", {27'd0, rf_rs1_o}, {27'd0, p_rs1_i});
            chk("pass_rs2", {27'd0, rf_rs2_o}, {27'd0, p_rs2_i});
            chk("pass_rd", {27'd0, rf_rd_o}, {27'd0, p_rd_i});
            chk("pass_val", rf_rd_value_o, p_rd_value_i);
            chk("pass_store", {31'd0, rf_rd_store_o}, {31'd0, p_rd_store_i});
        end else
            chk("own_store", {31'd0, rf_rd_store_o}, 32'd0);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 100 && !init_done_o; i++) begin
            if (rf_rd_store_o) n++;
            tick();
        end
    endtask

    task automatic do_txn(input bit we, input logic [4:0] a, input logic [31:0] d,
                          input int idle_wait, input int hold, output int lat, output int fall);
        dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d; dbg_req_i = 1'b1;
        p_rd_store_i = 1'b0;
        p_idle_i = idle_wait == 0;
        for (int i = 0; i < idle_wait; i++) begin
            tick();
            chk("drain_stall", {31'd0, stall_o}, 32'd1);
            chk("drain_nostore", {31'd0, rf_rd_store_o}, 32'd0);
        end
        p_idle_i = 1'b1;
        lat = 0;
        while (!dbg_ack_o && lat < 20) begin tick(); lat++; end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ack_hold", {31'd0, dbg_ack_o}, 32'd1);
        end
        dbg_req_i = 1'b0;
        fall = 0;
        while (stall_o && fall < 20) begin tick(); fall++; end
        tick();
    endtask

    logic [4:0]  v_rs [4] = '{5'd1, 5'd17, 5'd31, 5'd0};
    logic [31:0] v_val [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5A5A_A5A5};

    initial begin
        int lat, fall, n;
        #2 rst_i = 1'b1;
        #1;
        chk("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rst_rdata", dbg_rdata_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, {31'd0, CLR});
        chk("rst_done", {31'd0, init_done_o}, {31'd0, !CLR});
        tick(); tick();
        rst_i = 1'b0;
        wait_init(n);
        chk("clear_cycles", n, CLR ? 31 : 0);
        chk("init_stall", {31'd0, stall_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            p_rs1_i = v_rs[i]; p_rs2_i = v_rs[3 - i]; p_rd_i = v_rs[(i + 1) % 4];
            p_rd_value_i = v_val[i]; p_rd_store_i = i[0];
            #1 chk("vec_rs1", {27'd0, rf_rs1_o}, {27'd0, v_rs[i]});
            tick();
        end
        p_rd_store_i = 1'b0;
        do_txn(1'b1, 5'd5, 32'hDEADBEEF, 0, 0, lat, fall);
        chk("wr_lat", lat, 3);
        chk("wr_fall", fall, 2);
        do_txn(1'b0, 5'd5, 32'd0, 0, 0, lat, fall);
        chk("rd_lat", lat, 4);
        chk("rd_x5", dbg_rdata_o, 32'hDEADBEEF);
        do_txn(1'b1, 5'd0, 32'h12345678, 0, 0, lat, fall);
        chk("wr0_lat", lat, 3);
        do_txn(1'b0, 5'd0, 32'd0, 0, 0, lat, fall);
        chk("rd_x0", dbg_rdata_o, 32'd0);
        p_rs1_i = 5'd9; p_rs2_i = 5'd10;
        do_txn(1'b0, 5'd5, 32'd0, 10, 0, lat, fall);
        chk("drain_lat", lat, 3);
        chk("drain_x5", dbg_rdata_o, 32'hDEADBEEF);
        do_txn(1'b1, 5'd3, 32'hAAAA5555, 0, 5, lat, fall);
        chk("hold_lat", lat, 3);
        chk("hold_fall", fall, 2);
        do_txn(1'b0, 5'd3, 32'd0, 0, 0, lat, fall);
        chk("rd_x3", dbg_rdata_o, 32'hAAAA5555);
        // reset while the read of x7 is in READ_WAIT
        dbg_we_i = 1'b0; dbg_addr_i = 5'd7; dbg_req_i = 1'b1;
        tick(); tick(); tick();
        #3 rst_i = 1'b1;
        #1;
        chk("rw_rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rw_rst_rdata", dbg_rdata_o, 32'd0);
        chk("rw_rst_stall", {31'd0, stall_o}, {31'd0, CLR});
        dbg_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        if (CLR) begin
            chk("restart_rd", {27'd0, rf_rd_o}, 32'd1);
            chk("restart_store", {31'd0, rf_rd_store_o}, 32'd1);
        end
        wait_init(n);
        chk("reclear_cycles", n, CLR ? 31 : 0);
        // reset while acknowledging a write
        dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h0BAD_F00D; dbg_req_i = 1'b1;
        tick(); tick(); tick();
        chk("ack_before_rst", {31'd0, dbg_ack_o}, 32'd1);
        #3 rst_i = 1'b1;
        #1 chk("ack_rst", {31'd0, dbg_ack_o}, 32'd0);
        dbg_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        wait_init(n);
        do_txn(1'b0, 5'd9, 32'd0, 0, 0, lat, fall);
        chk("rd_x9", dbg_rdata_o, CLR ? 32'd0 : 32'h0BAD_F00D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
